// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and helpers for the period_timer block.
//   timer_state_t  : controller state (idle, running, one-shot finished)
//   restart_state(): state entered after reset or a synchronous clear
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } timer_state_t;

  // With auto-start enabled, periodic mode comes out of reset/clear already
  // counting. One-shot mode always waits for an explicit start.
  function automatic timer_state_t restart_state(input logic auto_start,
                                                 input logic oneshot);
    return (auto_start && !oneshot) ? T_RUN : T_IDLE;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides enabled clock cycles by div_in+1 and flags the cycle on which the
// main counter should advance.
//   clk_in   in  1      clock, posedge
//   rst_in   in  1      synchronous reset, active low
//   run      in  1      main timer is in its running state
//   en       in  1      advance enable; 0 freezes the divider
//   clr      in  1      synchronous restart of the divider (clear or start)
//   div_in   in  PRE_W  divide ratio minus one (shadowed value)
//   step_out out 1      high on the enabled cycle that completes a division
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             run,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div_in,
  output logic             step_out
);

  logic [PRE_W-1:0] pre_cnt;

  // The step is the last cycle of each division; a divide value of zero
  // therefore steps on every enabled cycle.
  assign step_out = run && en && (pre_cnt == div_in);

  // Divider count. It sits at zero whenever the timer is not running so a
  // fresh run always starts a full division. div_in only changes while the
  // count is zero, so pre_cnt can never run past it.
  always_ff @(posedge clk_in) begin
    if (!rst_in || clr || !run) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= step_out ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/period_timer.sv
// ---------------------------------------------------------------------------
// period_timer
// Programmable period counter with prescaler, one-shot/periodic modes and a
// single-cycle tick on every wrap. Period and prescale are shadowed so a
// running period is never disturbed by new input values.
//   clk_in      in  1      clock, posedge
//   rst_in      in  1      synchronous reset, active low
//   en_in       in  1      advance enable; 0 freezes counters, no tick
//   start_in    in  1      start / restart request
//   clear_in    in  1      synchronous clear to the restart state
//   oneshot_in  in  1      mode, captured on reset/clear/start (1 = one-shot)
//   period_in   in  WIDTH  counts per period (0 behaves as 1)
//   prescale_in in  PRE_W  steps every prescale_in+1 enabled cycles
//   count_out   out WIDTH  current count, 0..period-1
//   tick_out    out 1      one-cycle pulse on each wrap
//   busy_out    out 1      running
//   done_out    out 1      one-shot finished
// ---------------------------------------------------------------------------
module period_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PRE_W      = 16,
  parameter bit AUTO_START = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             start_in,
  input  logic             clear_in,
  input  logic             oneshot_in,
  input  logic [WIDTH-1:0] period_in,
  input  logic [PRE_W-1:0] prescale_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tick_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam logic [WIDTH-1:0] PERIOD_ONE = WIDTH'(1);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] period_q;
  logic [PRE_W-1:0] prescale_q;
  logic             mode_q;
  logic             load_shadow;
  logic             load_mode;
  logic             step;
  logic             wrap;

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .run      (state_q == T_RUN),
    .en       (en_in),
    .clr      (clear_in | start_in),
    .div_in   (prescale_q),
    .step_out (step)
  );

  // Periods of 0 and 1 wrap on every step; the subtraction is only
  // meaningful for larger periods, where it cannot underflow.
  assign wrap = (period_q <= PERIOD_ONE) || (count_q == period_q - PERIOD_ONE);

  // Next-state logic. Clear beats start, start beats stepping. Outside RUN
  // the count is held at zero and the shadows follow the inputs every cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tick_d      = 1'b0;
    load_shadow = 1'b0;
    load_mode   = 1'b0;
    if (clear_in) begin
      state_d     = restart_state(AUTO_START, oneshot_in);
      count_d     = '0;
      load_shadow = 1'b1;
      load_mode   = 1'b1;
    end else if (start_in) begin
      state_d     = T_RUN;
      count_d     = '0;
      load_shadow = 1'b1;
      load_mode   = 1'b1;
    end else begin
      case (state_q)
        T_RUN: begin
          if (step) begin
            if (wrap) begin
              count_d     = '0;
              tick_d      = 1'b1;
              load_shadow = 1'b1;
              if (mode_q) begin
                state_d = T_DONE;
              end
            end else begin
              count_d = count_q + PERIOD_ONE;
            end
          end
        end
        T_IDLE, T_DONE: begin
          count_d     = '0;
          load_shadow = 1'b1;
        end
        default: begin
          state_d     = T_IDLE;
          count_d     = '0;
          load_shadow = 1'b1;
        end
      endcase
    end
  end

  // Controller state, main count and tick. Reset lands in the same place a
  // clear does.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= restart_state(AUTO_START, oneshot_in);
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  // Period/prescale shadows: only reloaded at period boundaries or while
  // not counting, so a mid-period edit takes effect at the next wrap.
  always_ff @(posedge clk_in) begin
    if (!rst_in || load_shadow) begin
      period_q   <= period_in;
      prescale_q <= prescale_in;
    end
  end

  // Mode is latched only when a new run is armed, never at a wrap.
  always_ff @(posedge clk_in) begin
    if (!rst_in || load_mode) begin
      mode_q <= oneshot_in;
    end
  end

  assign count_out = count_q;
  assign tick_out  = tick_q;
  assign busy_out  = (state_q == T_RUN);
  assign done_out  = (state_q == T_DONE);

endmodule

// File: tb/tb_period_timer.sv
// ---------------------------------------------------------------------------
// tb_period_timer
// Self-checking bench for period_timer (WIDTH=8, PRE_W=4, AUTO_START=1).
// Expected outputs come from a reference model that tracks elapsed enabled
// cycles in the current period rather than separate counters.
// ---------------------------------------------------------------------------
module tb_period_timer;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             en_in;
  logic             start_in;
  logic             clear_in;
  logic             oneshot_in;
  logic [WIDTH-1:0] period_in;
  logic [PRE_W-1:0] prescale_in;
  logic [WIDTH-1:0] count_out;
  logic             tick_out;
  logic             busy_out;
  logic             done_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: where we are inside the current period, in enabled
  // cycles, plus the period/divider captured for that period.
  bit m_run;
  bit m_done;
  bit m_tick;
  bit m_mode;
  int m_elapsed;
  int m_period;
  int m_div;

  period_timer #(
    .WIDTH      (WIDTH),
    .PRE_W      (PRE_W),
    .AUTO_START (1'b1)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_in       (en_in),
    .start_in    (start_in),
    .clear_in    (clear_in),
    .oneshot_in  (oneshot_in),
    .period_in   (period_in),
    .prescale_in (prescale_in),
    .count_out   (count_out),
    .tick_out    (tick_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Enabled cycles in one full period.
  function automatic int spanOf(input int period, input int div);
    return (div + 1) * ((period == 0) ? 1 : period);
  endfunction

  function automatic int expCount();
    return m_elapsed / (m_div + 1);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelClock();
    if (!rst_in || clear_in) begin
      m_elapsed = 0;
      m_tick    = 1'b0;
      m_mode    = oneshot_in;
      m_period  = int'(period_in);
      m_div     = int'(prescale_in);
      m_run     = !oneshot_in;
      m_done    = 1'b0;
    end else if (start_in) begin
      m_elapsed = 0;
      m_tick    = 1'b0;
      m_mode    = oneshot_in;
      m_period  = int'(period_in);
      m_div     = int'(prescale_in);
      m_run     = 1'b1;
      m_done    = 1'b0;
    end else if (m_run) begin
      m_tick = 1'b0;
      if (en_in) begin
        m_elapsed++;
        if (m_elapsed == spanOf(m_period, m_div)) begin
          m_elapsed = 0;
          m_tick    = 1'b1;
          m_period  = int'(period_in);
          m_div     = int'(prescale_in);
          if (m_mode) begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end else begin
      m_tick    = 1'b0;
      m_elapsed = 0;
      m_period  = int'(period_in);
      m_div     = int'(prescale_in);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic checkAll();
    checkOutput("count", 32'(count_out), 32'(expCount()));
    checkOutput("tick", 32'(tick_out), 32'(m_tick));
    checkOutput("busy", 32'(busy_out), 32'(m_run));
    checkOutput("done", 32'(done_out), 32'(m_done));
  endtask

  // One clock: model and DUT see the same inputs, outputs sampled 1ns later.
  task automatic applyStimulus();
    modelClock();
    @(posedge clk_in);
    #1;
    checkAll();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
    end
  endtask

  task automatic pulseClear();
    clear_in = 1'b1;
    applyStimulus();
    clear_in = 1'b0;
  endtask

  task automatic pulseStart();
    start_in = 1'b1;
    applyStimulus();
    start_in = 1'b0;
  endtask

  // Step until the next enabled cycle would wrap, within a cycle budget.
  task automatic runUntilBeforeWrap(input int budget);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      if (m_run && m_elapsed == spanOf(m_period, m_div) - 1) begin
        reached = 1'b1;
      end else begin
        applyStimulus();
      end
    end
    n_checks++;
    assert (reached) n_pass++;
    else $error("[TB] FAIL wrap_wait observed=timeout expected=reached");
  endtask

  task automatic runUntilCount(input int target, input int budget);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      if (m_run && expCount() == target) begin
        reached = 1'b1;
      end else begin
        applyStimulus();
      end
    end
    n_checks++;
    assert (reached) n_pass++;
    else $error("[TB] FAIL count_wait observed=timeout expected=reached");
  endtask

  int seq_count [8];
  int seq_tick  [8];

  initial begin
    rst_in      = 1'b0;
    en_in       = 1'b1;
    start_in    = 1'b0;
    clear_in    = 1'b0;
    oneshot_in  = 1'b0;
    period_in   = 8'd4;
    prescale_in = 4'd0;
    #1;

    // Reset for two cycles, then a free-running period of 4.
    runCycles(2);
    checkOutput("rst_count", 32'(count_out), 32'd0);
    checkOutput("rst_busy", 32'(busy_out), 32'd1);
    checkOutput("rst_tick", 32'(tick_out), 32'd0);
    rst_in    = 1'b1;
    seq_count = '{1, 2, 3, 0, 1, 2, 3, 0};
    seq_tick  = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput("seq_count", 32'(count_out), 32'(seq_count[i]));
      checkOutput("seq_tick", 32'(tick_out), 32'(seq_tick[i]));
    end

    // Prescaled period: count every 3rd cycle, tick every 9.
    period_in   = 8'd3;
    prescale_in = 4'd2;
    pulseClear();
    runCycles(8);
    checkOutput("pre_before_wrap", 32'(tick_out), 32'd0);
    applyStimulus();
    checkOutput("pre_wrap_tick", 32'(tick_out), 32'd1);
    runCycles(12);

    // One-shot of 5, then an identical retrigger from DONE.
    oneshot_in  = 1'b1;
    period_in   = 8'd5;
    prescale_in = 4'd0;
    pulseClear();
    checkOutput("os_idle", 32'(busy_out), 32'd0);
    runCycles(2);
    for (int r = 0; r < 2; r++) begin
      pulseStart();
      runCycles(4);
      checkOutput("os_busy", 32'(busy_out), 32'd1);
      applyStimulus();
      checkOutput("os_done", 32'(done_out), 32'd1);
      checkOutput("os_tick", 32'(tick_out), 32'd1);
      runCycles(3);
      checkOutput("os_hold", 32'(count_out), 32'd0);
    end

    // Shadowed period change mid-run takes effect only at the wrap.
    oneshot_in = 1'b0;
    period_in  = 8'd8;
    pulseClear();
    runUntilCount(2, 20);
    period_in = 8'd3;
    runCycles(5);
    checkOutput("shadow_count", 32'(count_out), 32'd7);
    applyStimulus();
    checkOutput("shadow_tick", 32'(tick_out), 32'd1);
    runCycles(9);

    // Start on the wrap cycle suppresses the tick.
    period_in = 8'd4;
    pulseClear();
    runUntilBeforeWrap(50);
    pulseStart();
    checkOutput("start_wrap_tick", 32'(tick_out), 32'd0);
    checkOutput("start_wrap_count", 32'(count_out), 32'd0);
    runCycles(3);

    // Clear together with start: clear wins, one-shot restart state is IDLE.
    oneshot_in = 1'b1;
    clear_in   = 1'b1;
    start_in   = 1'b1;
    applyStimulus();
    clear_in   = 1'b0;
    start_in   = 1'b0;
    checkOutput("clr_start_busy", 32'(busy_out), 32'd0);
    runCycles(2);
    oneshot_in = 1'b0;

    // Period 0 and 1 with no prescale tick every cycle at count 0.
    for (int p = 0; p < 2; p++) begin
      period_in = WIDTH'(p);
      pulseClear();
      for (int i = 0; i < 4; i++) begin
        applyStimulus();
        checkOutput("cont_tick", 32'(tick_out), 32'd1);
      end
    end

    // Enable low mid-count freezes everything, then resumes.
    period_in   = 8'd6;
    prescale_in = 4'd1;
    pulseClear();
    runCycles(5);
    en_in = 1'b0;
    runCycles(4);
    en_in = 1'b1;
    runCycles(12);

    // Reset mid-run.
    rst_in = 1'b0;
    applyStimulus();
    checkOutput("mid_rst_count", 32'(count_out), 32'd0);
    rst_in = 1'b1;
    runCycles(3);

    // Largest period: counts up to 254 before wrapping.
    period_in   = 8'd255;
    prescale_in = 4'd0;
    pulseClear();
    runCycles(254);
    checkOutput("max_count", 32'(count_out), 32'd254);
    runCycles(4);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst_in   = ($urandom % 200) != 0;
      clear_in = ($urandom % 60) == 0;
      start_in = ($urandom % 40) == 0;
      en_in    = ($urandom % 5) != 0;
      if (($urandom % 30) == 0) oneshot_in = $urandom % 2;
      if (($urandom % 25) == 0) period_in = WIDTH'($urandom_range(0, 9));
      if (($urandom % 25) == 0) prescale_in = PRE_W'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
